// File: rtl/sipo_deframer_if.sv
// Serial-in and word-out signal bundle for sipo_deframer.
// slave: the deframer. master: the upstream serial source and the word consumer.
interface sipo_deframer_if #(
    parameter int unsigned WIDTH = 4
);
    localparam int unsigned CW = $clog2(WIDTH);

    logic             si;
    logic             si_en;
    logic             sync;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic [CW-1:0]    bit_cnt;
    logic             locked;
    logic             overflow;
    logic             overflow_clr;

    modport slave (
        input  si, si_en, sync, dout_ready, overflow_clr,
        output dout, dout_valid, bit_cnt, locked, overflow
    );

    modport master (
        output si, si_en, sync, dout_ready, overflow_clr,
        input  dout, dout_valid, bit_cnt, locked, overflow
    );
endinterface

// File: rtl/sipo_deframer.sv
// Serial-in parallel-out deframer: aligns on sync, assembles WIDTH-bit words and
// presents them through a one-entry valid/ready register with a sticky overflow flag.
module sipo_deframer #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b0
) (
    input logic            clk,
    input logic            rst_n,
    sipo_deframer_if.slave bus
);
    localparam int unsigned   CW      = $clog2(WIDTH);
    localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);

    typedef enum logic [0:0] {StHunt, StShift} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             overflow_q, overflow_d;

    logic             capture;
    logic             complete;
    logic             can_load;
    logic [CW-1:0]    pos;
    logic [CW-1:0]    slot;

    // Framing: a qualified sync always restarts at bit 0, whatever the state.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        capture  = 1'b0;
        complete = 1'b0;
        pos      = bus.sync ? '0 : cnt_q;
        slot     = MSB_FIRST ? (LastBit - pos) : pos;

        if (bus.si_en) begin
            unique case (state_q)
                StHunt: begin
                    if (bus.sync) begin
                        capture = 1'b1;
                        cnt_d   = CW'(1);
                        state_d = StShift;
                    end
                end
                StShift: begin
                    capture = 1'b1;
                    if (bus.sync) begin
                        cnt_d = CW'(1);
                    end else if (cnt_q == LastBit) begin
                        complete = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: state_d = StHunt;
            endcase
        end

        if (capture) begin
            shreg_d[slot] = bus.si;
        end
    end

    // The completed word is shreg_d, so the final bit lands in the same edge.
    always_comb begin
        can_load     = !dout_valid_q || bus.dout_ready;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        overflow_d   = overflow_q;

        if (bus.overflow_clr) begin
            overflow_d = 1'b0;
        end

        if (complete && can_load) begin
            dout_d       = shreg_d;
            dout_valid_d = 1'b1;
        end else if (bus.dout_ready) begin
            dout_valid_d = 1'b0;
        end

        if (complete && !can_load) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StHunt;
            cnt_q        <= '0;
            shreg_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overflow_q   <= overflow_d;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.bit_cnt    = cnt_q;
    assign bus.locked     = (state_q == StShift);
    assign bus.overflow   = overflow_q;

    a_dout_held: assert property (@(posedge clk) disable iff (!rst_n)
        (dout_valid_q && !bus.dout_ready) |=> $stable(dout_q));

    a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n)
        cnt_q <= LastBit);

    a_hunt_idle: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == StHunt) |-> (cnt_q == '0));
endmodule

// File: tb/tb_sipo_deframer.sv
// Randomized and directed bench for sipo_deframer: LSB-first and MSB-first instances share
// stimulus; a bit-queue reference model feeds per-instance scoreboards drained by a monitor.
module tb_sipo_deframer;
    localparam int unsigned W  = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    sipo_deframer_if #(.WIDTH(W)) bus_a ();
    sipo_deframer_if #(.WIDTH(W)) bus_b ();

    sipo_deframer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    sipo_deframer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: bits received since the last alignment point.
    bit m_bits[$];
    bit m_locked;
    bit m_valid;
    bit m_ovf;
    int q_a[$];
    int q_b[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pack_word(input bit msb);
        int w;
        int sh;
        w = 0;
        for (int k = 0; k < int'(W); k++) begin
            sh = msb ? (int'(W) - 1 - k) : k;
            if (m_bits[k]) w = w | (1 << sh);
        end
        return w;
    endfunction

    task automatic model_clear();
        m_bits.delete();
        m_locked = 1'b0;
        m_valid  = 1'b0;
        m_ovf    = 1'b0;
        q_a.delete();
        q_b.delete();
    endtask

    // Applies the rules for one clock edge to the inputs that were present at that edge.
    task automatic model_step();
        bit complete;
        bit dropped;
        complete = 1'b0;
        dropped  = 1'b0;
        if (!rst_n) begin
            model_clear();
            return;
        end
        if (bus_a.si_en) begin
            if (bus_a.sync) begin
                m_locked = 1'b1;
                m_bits.delete();
            end
            if (m_locked) begin
                m_bits.push_back(bus_a.si);
                if (m_bits.size() == int'(W)) complete = 1'b1;
            end
        end
        if (complete) begin
            if (!m_valid || bus_a.dout_ready) begin
                q_a.push_back(pack_word(1'b0));
                q_b.push_back(pack_word(1'b1));
                m_valid = 1'b1;
            end else begin
                dropped = 1'b1;
            end
            m_bits.delete();
        end else if (bus_a.dout_ready) begin
            m_valid = 1'b0;
        end
        if (bus_a.overflow_clr) m_ovf = 1'b0;
        if (dropped) m_ovf = 1'b1;
    endtask

    task automatic drive(input bit si, input bit en, input bit sy, input bit rdy, input bit clr);
        bus_a.si = si;  bus_a.si_en = en;  bus_a.sync = sy;
        bus_a.dout_ready = rdy;  bus_a.overflow_clr = clr;
        bus_b.si = si;  bus_b.si_en = en;  bus_b.sync = sy;
        bus_b.dout_ready = rdy;  bus_b.overflow_clr = clr;
    endtask

    task automatic cycle(input bit si, input bit en, input bit sy, input bit rdy, input bit clr);
        drive(si, en, sy, rdy, clr);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n, input bit sync_first,
                             input bit rdy, input bit gaps);
        for (int i = 0; i < n; i++) begin
            cycle(bits[i], 1'b1, sync_first && (i == 0), rdy, 1'b0);
            if (gaps && i != n - 1) cycle(1'b0, 1'b0, 1'b0, rdy, 1'b0);
        end
    endtask

    task automatic do_reset(input int n);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        model_clear();
        repeat (n) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Monitor: status every cycle, words whenever a handshake completes.
    always @(negedge clk) begin
        check("valid_a", 32'(bus_a.dout_valid), 32'(m_valid));
        check("valid_b", 32'(bus_b.dout_valid), 32'(m_valid));
        check("locked_a", 32'(bus_a.locked), 32'(m_locked));
        check("bit_cnt_a", 32'(bus_a.bit_cnt), 32'(m_bits.size()));
        check("bit_cnt_b", 32'(bus_b.bit_cnt), 32'(m_bits.size()));
        check("overflow_a", 32'(bus_a.overflow), 32'(m_ovf));
        check("overflow_b", 32'(bus_b.overflow), 32'(m_ovf));
        if (bus_a.dout_valid && bus_a.dout_ready) begin
            check("sb_a_has_word", 32'(q_a.size() != 0), 32'd1);
            if (q_a.size() != 0) check("word_a", 32'(bus_a.dout), 32'(q_a.pop_front()));
        end
        if (bus_b.dout_valid && bus_b.dout_ready) begin
            check("sb_b_has_word", 32'(q_b.size() != 0), 32'd1);
            if (q_b.size() != 0) check("word_b", 32'(bus_b.dout), 32'(q_b.pop_front()));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_exp [6];
        logic [5:0] rs_si;
        logic [5:0] rs_sync;
        bit en, si, sy, rdy, clr;

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        model_clear();

        // Reset, then unsynced bits must leave it hunting.
        do_reset(3);
        repeat (5) cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        check("hunt_locked", 32'(bus_a.locked), 32'd0);
        check("hunt_bit_cnt", 32'(bus_a.bit_cnt), 32'd0);
        check("hunt_valid", 32'(bus_a.dout_valid), 32'd0);

        // Basic word 1,0,1,1.
        send_bits(16'h000D, 4, 1'b1, 1'b1, 1'b0);
        check("basic_valid", 32'(bus_a.dout_valid), 32'd1);
        check("basic_dout_a", 32'(bus_a.dout), 32'hD);
        check("basic_dout_b", 32'(bus_b.dout), 32'hB);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("basic_valid_drop", 32'(bus_a.dout_valid), 32'd0);

        // Back-to-back words with gaps, single sync.
        send_bits(16'h000D, 4, 1'b1, 1'b1, 1'b1);
        check("b2b_first", 32'(bus_a.dout), 32'hD);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send_bits(16'h0006, 4, 1'b0, 1'b1, 1'b1);
        check("b2b_second", 32'(bus_a.dout), 32'h6);
        check("b2b_overflow", 32'(bus_a.overflow), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Overflow under backpressure.
        send_bits(16'h00A3, 8, 1'b1, 1'b0, 1'b0);
        check("ovf_dout_a", 32'(bus_a.dout), 32'h3);
        check("ovf_dout_b", 32'(bus_b.dout), 32'hC);
        check("ovf_flag", 32'(bus_a.overflow), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("ovf_consumed", 32'(bus_a.dout_valid), 32'd0);
        check("ovf_sticky", 32'(bus_a.overflow), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("ovf_cleared", 32'(bus_a.overflow), 32'd0);

        // Resync after two bits.
        rs_si   = 6'b100011;
        rs_sync = 6'b000101;
        cnt_exp = '{1, 2, 1, 2, 3, 0};
        for (int i = 0; i < 6; i++) begin
            cycle(rs_si[i], 1'b1, rs_sync[i], 1'b1, 1'b0);
            check("resync_bit_cnt", 32'(bus_a.bit_cnt), 32'(cnt_exp[i]));
        end
        check("resync_dout_a", 32'(bus_a.dout), 32'h8);
        check("resync_dout_b", 32'(bus_b.dout), 32'h1);
        check("resync_overflow", 32'(bus_a.overflow), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Bit order, then asynchronous reset mid-word with a held word.
        send_bits(16'h0001, 4, 1'b1, 1'b0, 1'b0);
        check("order_dout_b", 32'(bus_b.dout), 32'h8);
        check("order_dout_a", 32'(bus_a.dout), 32'h1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        model_clear();
        #1;
        check("arst_valid_b", 32'(bus_b.dout_valid), 32'd0);
        check("arst_locked_b", 32'(bus_b.locked), 32'd0);
        check("arst_bit_cnt_b", 32'(bus_b.bit_cnt), 32'd0);
        check("arst_valid_a", 32'(bus_a.dout_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Randomized traffic with alternating backpressure phases.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 999) == 0) do_reset(2);
            en  = ($urandom_range(0, 3) != 0);
            si  = 1'($urandom);
            sy  = ($urandom_range(0, 15) == 0);
            rdy = ((i / 500) % 2 == 1) ? ($urandom_range(0, 7) == 0)
                                       : ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 31) == 0);
            cycle(si, en, sy, rdy, clr);
        end

        repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("sb_a_drained", 32'(q_a.size()), 32'd0);
        check("sb_b_drained", 32'(q_b.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
